mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage bridge to an SRAM-like data port.
// One outstanding access; builds strobes/data and extends loads.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_dram_re,
    input  logic        mem_dram_we,
    input  logic [31:0] mem_dram_addr,
    input  logic [31:0] mem_dram_wdata,
    input  logic [1:0]  mem_rdram_num,
    input  logic [1:0]  mem_wdram_num,
    input  logic        mem_rdram_need_signed_extend,
    input  logic        mem_rdram_need_zero_extend,
    input  logic        wb_allowin,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        mem_ready_go,
    output logic [31:0] mem_load_result,
    output logic        mem_ale
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [1:0]  lat_size;
    logic        lat_sext;
    logic        access;
    logic        misalign;
    logic [1:0]  size;
    logic [3:0]  wstrb_n;
    logic [31:0] wdata_n;
    logic [31:0] ld_ext;
    logic [31:0] cap_val;
    logic        unused_zext;

    // zero extension is the fallback, so its flag carries no information
    assign unused_zext = mem_rdram_need_zero_extend;

    // both re and we high is a store, so the store size wins
    assign access = mem_valid & (mem_dram_re | mem_dram_we);
    assign size   = mem_dram_we ? mem_wdram_num : mem_rdram_num;

    // alignment check and lane-replicated store payload
    always_comb begin
        misalign = 1'b0;
        wstrb_n  = 4'b0000;
        wdata_n  = mem_dram_wdata;
        unique case (size)
            2'b00: begin
                wstrb_n = 4'b0001 << mem_dram_addr[1:0];
                wdata_n = {4{mem_dram_wdata[7:0]}};
            end
            2'b01: begin
                misalign = mem_dram_addr[0];
                wstrb_n  = 4'b0011 << mem_dram_addr[1:0];
                wdata_n  = {2{mem_dram_wdata[15:0]}};
            end
            default: begin
                misalign = |mem_dram_addr[1:0];
                wstrb_n  = 4'b1111;
            end
        endcase
        if (!mem_dram_we) wstrb_n = 4'b0000;
    end

    // lane select and extension of returned read data
    always_comb begin
        unique case (lat_size)
            2'b00: begin
                ld_ext = {{24{lat_sext & data_rdata[{data_addr[1:0], 3'b111}]}},
                          data_rdata[{data_addr[1:0], 3'b000} +: 8]};
            end
            2'b01: begin
                ld_ext = {{16{lat_sext & data_rdata[{data_addr[1], 4'b1111}]}},
                          data_rdata[{data_addr[1], 4'b0000} +: 16]};
            end
            default: ld_ext = data_rdata;
        endcase
        cap_val = data_wr ? 32'h0 : ld_ext;
    end

    assign mem_ready_go = (state == DONE) |
                          ((state == IDLE) & ~(access & ~misalign));
    assign mem_ale      = (state == IDLE) & access & misalign & ~rst;

    // request FSM with registered bus payload and load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            data_req        <= 1'b0;
            data_wr         <= 1'b0;
            data_wstrb      <= 4'b0;
            data_addr       <= 32'h0;
            data_wdata      <= 32'h0;
            mem_load_result <= 32'h0;
            lat_size        <= 2'b0;
            lat_sext        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access && !misalign) begin
                        state      <= REQ;
                        data_req   <= 1'b1;
                        data_wr    <= mem_dram_we;
                        data_wstrb <= wstrb_n;
                        data_addr  <= mem_dram_addr;
                        data_wdata <= wdata_n;
                        lat_size   <= size;
                        lat_sext   <= mem_rdram_need_signed_extend;
                    end
                end
                REQ: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        if (data_data_ok) begin
                            mem_load_result <= cap_val;
                            state           <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (data_data_ok) begin
                        mem_load_result <= cap_val;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    if (wb_allowin) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
